tone_command_qualifier: RTL



---
 rtl/fury_pkg.sv | 42 ++++
 rtl/tone_command_qualifier_sync2.sv | 26 ++
 rtl/tone_command_qualifier.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fury_pkg.sv
// fury_pkg: shared definitions for the drive-side controllers.
//   dirCode_t   - junction command codes (also used by the drive state machine)
//   qualState_t - tone qualifier FSM encoding
//   toneToDir   - one-hot tone vector to direction code
//   isSingle    - true when exactly one tone line is high
package fury_pkg;

    typedef enum logic [2:0] {
        STRAIGHT = 3'b000,
        LEFT     = 3'b001,
        RIGHT    = 3'b010,
        BACK     = 3'b011,
        STOP     = 3'b100
    } dirCode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } qualState_t;

    function automatic dirCode_t toneToDir(input logic [4:0] s);
        dirCode_t d;
        d = STRAIGHT;
        case (s)
            5'b00001: d = STRAIGHT;
            5'b00010: d = LEFT;
            5'b00100: d = RIGHT;
            5'b01000: d = BACK;
            5'b10000: d = STOP;
            default:  d = STRAIGHT;
        endcase
        return d;
    endfunction

    // Clearing the lowest set bit leaves zero only for a one-hot vector.
    function automatic logic isSingle(input logic [4:0] s);
        return (s != 5'd0) && ((s & (s - 5'd1)) == 5'd0);
    endfunction

endpackage

// File: rtl/tone_command_qualifier_sync2.sv
// sync2: 1-bit two-flop synchroniser for asynchronous level inputs.
// Ports:
//   clk - system clock
//   rst - synchronous, active-high reset (clears both flops)
//   d   - asynchronous input
//   q   - synchronised output, two clk edges after d
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tone_command_qualifier.sv
// tone_command_qualifier: turns the five band-pass tone detector lines into a
// single debounced junction command with a valid/acknowledge handshake.
// Ports:
//   clk        - system clock (50 MHz)
//   rst        - synchronous, active-high reset
//   bp1..bp5   - asynchronous tone detector outputs, active-high
//   tdAck      - consumer accepts the command (only looked at while tdEn=1)
//   tdEn       - command valid
//   tdDir      - command code, holds last issued value while tdEn=0
//   tdConflict - one-cycle pulse when several tones appear while qualifying
//   toneActive - any synchronised tone line high
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | armed, waiting for a single tone
// QUALIFY | counting consecutive cycles of the candidate tone alone
// HOLD    | command presented (tdEn=1), waiting for tdAck
// RELEASE | counting consecutive silent cycles before re-arming
module tone_command_qualifier
    import fury_pkg::*;
#(
    parameter int QUAL_CYCLES = 2_500_000,
    parameter int REL_CYCLES  = 1_250_000,
    parameter int CNT_W       = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bp1,
    input  logic       bp2,
    input  logic       bp3,
    input  logic       bp4,
    input  logic       bp5,
    input  logic       tdAck,
    output logic       tdEn,
    output logic [2:0] tdDir,
    output logic       tdConflict,
    output logic       toneActive
);

    localparam logic [CNT_W-1:0] QUAL_LIMIT = CNT_W'(QUAL_CYCLES);
    localparam logic [CNT_W-1:0] REL_LIMIT  = CNT_W'(REL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [4:0]       bpRaw;
    logic [4:0]       s;
    logic             single;
    logic             silent;
    logic             multi;
    dirCode_t         code;

    qualState_t       state, nextState;
    logic [CNT_W-1:0] cnt, nextCnt;
    dirCode_t         cand, nextCand;
    dirCode_t         dirReg, nextDir;
    logic             conflictReg, nextConflict;
    logic             toneActReg;

    assign bpRaw = {bp5, bp4, bp3, bp2, bp1};

    for (genvar i = 0; i < 5; i++) begin : gSync
        sync2 uSync (
            .clk (clk),
            .rst (rst),
            .d   (bpRaw[i]),
            .q   (s[i])
        );
    end

    assign single = isSingle(s);
    assign silent = (s == 5'd0);
    assign multi  = !single && !silent;
    assign code   = toneToDir(s);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            cand        <= STRAIGHT;
            dirReg      <= STRAIGHT;
            conflictReg <= 1'b0;
            toneActReg  <= 1'b0;
        end else begin
            state       <= nextState;
            cnt         <= nextCnt;
            cand        <= nextCand;
            dirReg      <= nextDir;
            conflictReg <= nextConflict;
            toneActReg  <= |s;
        end
    end

    // Input conditions are tested before the terminal count, so a limit is
    // only honoured on a cycle whose input still satisfies the condition.
    always_comb begin
        nextState    = state;
        nextCnt      = cnt;
        nextCand     = cand;
        nextDir      = dirReg;
        nextConflict = 1'b0;
        case (state)
            IDLE: begin
                nextCnt = '0;
                if (single) begin
                    nextCand  = code;
                    nextCnt   = CNT_ONE;
                    nextState = QUALIFY;
                end
            end
            QUALIFY: begin
                if (multi) begin
                    nextConflict = 1'b1;
                    nextCnt      = '0;
                    nextState    = IDLE;
                end else if (single && (code == cand)) begin
                    if (cnt >= QUAL_LIMIT) begin
                        nextDir   = cand;
                        nextCnt   = '0;
                        nextState = HOLD;
                    end else if (cnt != CNT_MAX) begin
                        nextCnt = cnt + CNT_ONE;
                    end
                end else begin
                    nextCnt   = '0;
                    nextState = IDLE;
                end
            end
            HOLD: begin
                if (tdAck) begin
                    nextCnt   = '0;
                    nextState = RELEASE;
                end
            end
            RELEASE: begin
                if (!silent) begin
                    nextCnt = '0;
                end else if (cnt >= REL_LIMIT) begin
                    nextCnt   = '0;
                    nextState = IDLE;
                end else if (cnt != CNT_MAX) begin
                    nextCnt = cnt + CNT_ONE;
                end
            end
            default: begin
                nextCnt   = '0;
                nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        tdEn       = (state == HOLD);
        tdDir      = dirReg;
        tdConflict = conflictReg;
        toneActive = toneActReg;
    end

endmodule
